// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: datapath-wide basic types shared by the memory-side blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_types_pkg.sv
// icache_types_pkg: frame layout, FSM states and geometry for the direct-mapped icache.
package icache_types_pkg;
  import cpu_types_pkg::*;
  localparam int WORD_W = $bits(word_t);
  localparam int ICACHE_INDEX_BITS = 4;
  localparam int ICACHE_TAG_BITS = WORD_W - 2 - ICACHE_INDEX_BITS;
  typedef struct packed {
    logic valid;
    logic [ICACHE_TAG_BITS-1:0] tag;
    word_t data;
  } icache_frame_t;
  typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array: frame storage with a combinational read port, a synchronous
// write port and a flush-all that overrides any same-cycle write of the valid bit.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS = 26
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic                  wr_valid,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);
  localparam int FRAMES = 1 << INDEX_BITS;
  logic [FRAMES-1:0] valid;
  logic [TAG_BITS-1:0] tags [FRAMES];
  word_t data [FRAMES];
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_data = data[rd_index];
  always_ff @(posedge CLK or posedge RST)
    if (RST) valid <= '0;
    else if (flush) valid <= '0;
    else if (we) valid[wr_index] <= wr_valid;
  always_ff @(posedge CLK)
    if (we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped single-word-block instruction cache with a blocking miss FSM.
// Define ICACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module icache_dm
  import icache_types_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  icache_state_t state, state_n;
  logic [31:0] fill_addr;
  logic fill_kill, rd_valid, raw_hit, miss, fill;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0] rd_data;
  logic unused_byte_bits;
  assign unused_byte_bits = ^imemaddr[1:0];
  icache_frame_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_frames (
    .CLK(CLK),
    .RST(RST),
    .flush(iflush),
    .rd_index(imemaddr[1+INDEX_BITS:2]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .we(fill),
    .wr_valid(!fill_kill),
    .wr_index(fill_addr[1+INDEX_BITS:2]),
    .wr_tag(fill_addr[31:2+INDEX_BITS]),
    .wr_data(iload)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  always_comb begin
    raw_hit = (state == IDLE) && imemREN && rd_valid && (rd_tag == imemaddr[31:2+INDEX_BITS]);
    ihit = raw_hit && !iflush;
    imemload = ihit ? rd_data : '0;
    miss = (state == IDLE) && imemREN && !raw_hit;
    fill = (state == FETCH) && !iwait;
    iREN = (state == FETCH);
    iaddr = fill_addr;
    state_n = miss ? FETCH : fill ? IDLE : state;
  end
  // A flush seen at any point of a fill poisons that fill so stale data never becomes valid.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      fill_addr <= '0;
      fill_kill <= 1'b0;
    end else begin
      if (miss) fill_addr <= {imemaddr[31:2], 2'b00};
      fill_kill <= (state == FETCH) && !fill && (fill_kill || iflush);
    end
`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      hit_count <= hit_count + {31'b0, ihit && !(&hit_count)};
      miss_count <= miss_count + {31'b0, miss && !(&miss_count)};
    end
`endif
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed self-checking bench for icache_dm with a hand-driven memory side.
module tb_icache_dm;
  logic CLK, RST, imemREN, ihit, iflush, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif
  int vectors = 0;
  int miscompares = 0;

  icache_dm dut (
    .CLK(CLK),
    .RST(RST),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .ihit(ihit),
    .imemload(imemload),
    .iflush(iflush),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d, input int lat, input string nm);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = '0; #1;
    vectors++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      miscompares++;
      $display("FAIL %s miss: ihit=%b iREN=%b, required ihit=0 iREN=0", nm, ihit, iREN);
    end
    @(negedge CLK);
    for (int i = 0; i <= lat; i++) begin
      iwait = (i < lat); iload = (i == lat) ? d : 32'hDEADBEEF; #1;
      vectors++;
      if (iREN !== 1'b1 || iaddr !== {a[31:2], 2'b00} || ihit !== 1'b0) begin
        miscompares++;
        $display("FAIL %s fetch%0d: iREN=%b iaddr=%h ihit=%b, required iREN=1 iaddr=%h ihit=0",
                 nm, i, iREN, iaddr, ihit, {a[31:2], 2'b00});
      end
      @(negedge CLK);
    end
    iwait = 1'b1; iload = '0; #1;
    vectors++;
    if (ihit !== 1'b1 || imemload !== d || iREN !== 1'b0) begin
      miscompares++;
      $display("FAIL %s refill hit: ihit=%b imemload=%h iREN=%b, required ihit=1 imemload=%h iREN=0",
               nm, ihit, imemload, iREN, d);
    end
    @(negedge CLK);
  endtask

  task automatic hit_chk(input logic [31:0] a, input logic [31:0] d, input string nm);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; #1;
    vectors++;
    if (ihit !== 1'b1 || imemload !== d || iREN !== 1'b0) begin
      miscompares++;
      $display("FAIL %s hit: ihit=%b imemload=%h iREN=%b, required ihit=1 imemload=%h iREN=0",
               nm, ihit, imemload, iREN, d);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; iflush = 1'b0; iwait = 1'b1; iload = '0;
    @(negedge CLK); #1;
    vectors++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: ihit=%b iREN=%b iaddr=%h imemload=%h, required all 0", ihit, iREN, iaddr, imemload);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_cold_miss;
    miss_fill(32'h40, 32'h8C220004, 3, "cold_miss");
  endtask

  task automatic test_hit_after_fill;
    hit_chk(32'h40, 32'h8C220004, "hit_0x40");
    hit_chk(32'h42, 32'h8C220004, "hit_0x42");
  endtask

  task automatic test_conflict;
    miss_fill(32'h80, 32'h11111111, 1, "conflict_0x80");
    hit_chk(32'h80, 32'h11111111, "conflict_hit_0x80");
    miss_fill(32'h40, 32'h8C220004, 2, "conflict_evicted_0x40");
  endtask

  task automatic test_flush_during_fill;
    imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b1; #1;
    vectors++;
    if (ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_fill miss: ihit=%b, required 0", ihit);
    end
    @(negedge CLK);
    iflush = 1'b1; #1;
    vectors++;
    if (iREN !== 1'b1 || iaddr !== 32'h44 || ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_fill fetch: iREN=%b iaddr=%h ihit=%b, required 1 00000044 0", iREN, iaddr, ihit);
    end
    @(negedge CLK);
    iflush = 1'b0; iwait = 1'b0; iload = 32'h22222222; #1;
    vectors++;
    if (iREN !== 1'b1 || ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_fill completes: iREN=%b ihit=%b, required iREN=1 ihit=0", iREN, ihit);
    end
    @(negedge CLK);
    imemREN = 1'b0; iwait = 1'b1; iload = '0; #1;
    vectors++;
    if (iREN !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_fill idle: iREN=%b, required 0", iREN);
    end
    @(negedge CLK);
    miss_fill(32'h44, 32'h22222222, 1, "flush_refill_0x44");
    miss_fill(32'h40, 32'h8C220004, 1, "flush_refill_0x40");
  endtask

  task automatic test_addr_change;
    imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1; #1;
    vectors++;
    if (ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_change miss 0x100: ihit=%b, required 0", ihit);
    end
    @(negedge CLK);
    imemaddr = 32'h200; #1;
    vectors++;
    if (iREN !== 1'b1 || iaddr !== 32'h100) begin
      miscompares++;
      $display("FAIL addr_change fetch: iREN=%b iaddr=%h, required 1 00000100", iREN, iaddr);
    end
    @(negedge CLK);
    iwait = 1'b0; iload = 32'h33333333; #1;
    vectors++;
    if (iREN !== 1'b1 || iaddr !== 32'h100 || ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_change fill: iREN=%b iaddr=%h ihit=%b, required 1 00000100 0", iREN, iaddr, ihit);
    end
    @(negedge CLK);
    iwait = 1'b1; iload = '0; #1;
    vectors++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_change remiss 0x200: ihit=%b iREN=%b, required 0 0", ihit, iREN);
    end
    @(negedge CLK);
    iwait = 1'b0; iload = 32'h44444444; #1;
    vectors++;
    if (iREN !== 1'b1 || iaddr !== 32'h200) begin
      miscompares++;
      $display("FAIL addr_change fetch 0x200: iREN=%b iaddr=%h, required 1 00000200", iREN, iaddr);
    end
    @(negedge CLK);
    iwait = 1'b1; iload = '0;
    hit_chk(32'h200, 32'h44444444, "addr_change_hit_0x200");
  endtask

  task automatic test_flush_idle;
    imemREN = 1'b1; imemaddr = 32'h200; iflush = 1'b1; #1;
    vectors++;
    if (ihit !== 1'b0 || imemload !== 32'h0) begin
      miscompares++;
      $display("FAIL flush_idle: ihit=%b imemload=%h, required 0 00000000", ihit, imemload);
    end
    @(negedge CLK);
    iflush = 1'b0;
    miss_fill(32'h200, 32'h55555555, 0, "flush_idle_refill");
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_counters;
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    miss_fill(32'h40, 32'h8C220004, 1, "perf_0x40");
    miss_fill(32'h44, 32'h22222222, 1, "perf_0x44");
    hit_chk(32'h44, 32'h22222222, "perf_hit");
    imemREN = 1'b0; #1;
    vectors++;
    if (miss_count !== 32'd2 || hit_count !== 32'd3) begin
      miscompares++;
      $display("FAIL perf counts: miss_count=%0d hit_count=%0d, required 2 3", miss_count, hit_count);
    end
    @(negedge CLK);
    RST = 1'b1; #1;
    vectors++;
    if (miss_count !== 32'd0 || hit_count !== 32'd0) begin
      miscompares++;
      $display("FAIL perf reset: miss_count=%0d hit_count=%0d, required 0 0", miss_count, hit_count);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_conflict();
    test_flush_during_fill();
    test_addr_change();
    test_flush_idle();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, single-word-block instruction cache.
- Sits on the cache side of the datapath instruction-fetch interface. It answers the pipeline's imemREN/imemaddr requests with ihit/imemload.
- On a miss it acts as initiator toward the memory controller using iREN/iaddr, and waits on iwait/iload.
- Read-only: it has no store path and never writes back.

Parameters:
- INDEX_BITS, 4: log2 of frame count; 16 frames by default.
- TAG_BITS, 30-INDEX_BITS: derived, not overridable. Upper address bits stored per frame.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word; valid only when ihit=1.
- iflush  in  1  invalidate all frames (synchronous).
- iREN  out  1  read request to memory controller.
- iaddr  out  32  word-aligned memory address.
- iwait  in  1  memory busy; iload valid on the cycle iwait=0 with iREN=1.
- iload  in  32  memory read data.

Behaviour:
- Address split: tag=imemaddr[31:2+INDEX_BITS], index=imemaddr[1+INDEX_BITS:2], [1:0] dropped.
- Frame contents: valid, tag, data.
- Reset (RST=1, async): all valid bits cleared, state=IDLE. Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
- State IDLE:
  - Hit = imemREN & valid[index] & (tag match).
  - On a hit, ihit=1 and imemload=data[index], both combinational in the same cycle.
  - On imemREN & !hit, go to FETCH. Latch the miss word address into fill_addr. ihit=0.
  - With imemREN=0: ihit=0, no transition.
- State FETCH:
  - iREN=1, iaddr={fill_addr[31:2],2'b00}, ihit=0.
  - On the cycle iwait=0, write frame[fill_index] <= {1, fill_tag, iload} and return to IDLE.
  - The requested word hits on the next cycle. Miss latency = memory latency + 1 cycle; hit latency = 0.
- No bypass: the fill cycle itself never asserts ihit.
- imemaddr changing during FETCH: the fill completes for the latched fill_addr. IDLE then re-evaluates the new address, which may miss again.
- imemREN dropping during FETCH: the fill still completes; it is never abandoned.
- iflush=1:
  - All valid bits cleared at the next edge.
  - If in FETCH, the in-flight fill continues to completion, but the frame is written with valid=0. Flush wins over a simultaneous fill write.
  - In IDLE, ihit is forced to 0 in the flush cycle.
- Outputs in IDLE: iREN=0; iaddr holds its last value.
- Same-index conflict: a new fill overwrites the frame unconditionally.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined, adds two 32-bit outputs: hit_count and miss_count.
  - hit_count increments once per cycle with ihit=1.
  - miss_count increments once per IDLE->FETCH transition.
  - Both reset to 0 on RST and saturate at 32'hFFFFFFFF.
  - iflush does not clear them.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package icache_types_pkg holds:
  - icache_frame_t: packed struct {valid, tag[TAG_BITS], data[32]}.
  - icache_state_t: enum {IDLE, FETCH}.
  - Widths are taken from cpu_types_pkg word_t.
- Sub-module icache_frame_array holds the frame storage:
  - one read port, combinational, indexed by the current index;
  - one write port, synchronous;
  - a flush-all input.
- The top level keeps the FSM, tag compare, fill latch and counters.

Test Plan:
- Cold miss:
  - Stimulus: after RST, imemREN=1, imemaddr=0x00000040, memory holds 0x8C220004, iwait high 3 cycles.
  - Required: iREN=1 and iaddr=0x40 for 4 cycles, ihit=0, then ihit=1 with imemload=0x8C220004 on the following cycle.
- Hit after fill: re-request 0x40 and then 0x42 → ihit=1 in the same cycle both times, no iREN.
- Conflict eviction:
  - Stimulus: fill 0x40, then request 0x80 (same index 0, different tag).
  - Required: 0x80 misses and is filled; a re-request of 0x40 misses again.
- Flush during fill:
  - Stimulus: assert iflush while in FETCH for 0x44.
  - Required: the fill completes, then a request to 0x44 misses again; 0x40, previously valid, also misses.
- Address change mid-miss:
  - Stimulus: miss on 0x100, then imemaddr switches to 0x200 before iwait falls.
  - Required: the fill writes 0x100, then 0x200 misses with iaddr=0x200.
- With ICACHE_PERF_CNT_EN: 2 misses and 3 hit cycles → miss_count=2, hit_count=3; RST returns both to 0.
